// File: rtl/load_store_unit.sv
// Load/store unit: initiator side of the byte-addressed data SRAM port.
// Takes one request at a time, drives one SRAM access cycle and returns a
// registered, sign/zero-extended response with an error flag.
module load_store_unit #(
    parameter int unsigned ADDR_W      = 16,
    parameter bit          CHECK_ALIGN = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_is_store,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic [ADDR_W-1:0] mem_address,
    output logic [3:0]        mem_w_en,
    output logic [31:0]       mem_write_data,
    input  logic [31:0]       mem_read_data
);

    localparam int unsigned DATA_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic                is_store_q, is_store_d;
    logic [2:0]          funct3_q, funct3_d;
    logic                req_ready_q, req_ready_d;
    logic                resp_valid_q, resp_valid_d;
    logic [DATA_W-1:0]   resp_rdata_q, resp_rdata_d;
    logic                resp_err_q, resp_err_d;
    logic [ADDR_W-1:0]   mem_address_q, mem_address_d;
    logic [3:0]          mem_w_en_q, mem_w_en_d;
    logic [DATA_W-1:0]   mem_write_data_q, mem_write_data_d;

    logic                req_illegal_c;
    logic                req_misalign_c;

    // Byte-write-enable code for a store width; zero for anything else.
    function automatic logic [3:0] store_code(input logic [2:0] f3);
        case (f3)
            3'b000:  store_code = 4'b0001;
            3'b001:  store_code = 4'b0011;
            3'b010:  store_code = 4'b1111;
            default: store_code = 4'b0000;
        endcase
    endfunction

    // Sign/zero extension of raw SRAM read data according to load funct3.
    function automatic logic [DATA_W-1:0] load_extend(input logic [2:0] f3,
                                                      input logic [DATA_W-1:0] d);
        case (f3)
            3'b000:  load_extend = {{24{d[7]}}, d[7:0]};
            3'b100:  load_extend = {24'd0, d[7:0]};
            3'b001:  load_extend = {{16{d[15]}}, d[15:0]};
            3'b101:  load_extend = {16'd0, d[15:0]};
            default: load_extend = d;
        endcase
    endfunction

    // Classify the incoming request as illegal and/or misaligned.
    always_comb begin
        req_illegal_c  = 1'b0;
        req_misalign_c = 1'b0;
        if (req_is_store) begin
            req_illegal_c = !(req_funct3 inside {3'b000, 3'b001, 3'b010});
        end else begin
            req_illegal_c = !(req_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
        end
        if (CHECK_ALIGN) begin
            req_misalign_c = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                             ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
        end
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d          = state_q;
        is_store_d       = is_store_q;
        funct3_d         = funct3_q;
        resp_rdata_d     = resp_rdata_q;
        resp_err_d       = resp_err_q;
        mem_address_d    = mem_address_q;
        mem_write_data_d = mem_write_data_q;
        mem_w_en_d       = 4'b0000;

        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    if (req_illegal_c || req_misalign_c) begin
                        state_d      = ST_RESP;
                        resp_err_d   = 1'b1;
                        resp_rdata_d = '0;
                    end else begin
                        state_d          = ST_ACCESS;
                        is_store_d       = req_is_store;
                        funct3_d         = req_funct3;
                        mem_address_d    = req_addr;
                        mem_write_data_d = req_wdata;
                        // Enable is registered so it is live exactly during ACCESS.
                        if (req_is_store) begin
                            mem_w_en_d = store_code(req_funct3);
                        end
                    end
                end
            end
            ST_ACCESS: begin
                state_d    = ST_RESP;
                resp_err_d = 1'b0;
                if (is_store_q) begin
                    resp_rdata_d = '0;
                end else begin
                    resp_rdata_d = load_extend(funct3_q, mem_read_data);
                end
            end
            ST_RESP: begin
                if (resp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        req_ready_d  = (state_d == ST_IDLE);
        resp_valid_d = (state_d == ST_RESP);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q          <= ST_IDLE;
            is_store_q       <= 1'b0;
            funct3_q         <= 3'b000;
            req_ready_q      <= 1'b1;
            resp_valid_q     <= 1'b0;
            resp_rdata_q     <= '0;
            resp_err_q       <= 1'b0;
            mem_address_q    <= '0;
            mem_w_en_q       <= 4'b0000;
            mem_write_data_q <= '0;
        end else begin
            state_q          <= state_d;
            is_store_q       <= is_store_d;
            funct3_q         <= funct3_d;
            req_ready_q      <= req_ready_d;
            resp_valid_q     <= resp_valid_d;
            resp_rdata_q     <= resp_rdata_d;
            resp_err_q       <= resp_err_d;
            mem_address_q    <= mem_address_d;
            mem_w_en_q       <= mem_w_en_d;
            mem_write_data_q <= mem_write_data_d;
        end
    end

    assign req_ready      = req_ready_q;
    assign resp_valid     = resp_valid_q;
    assign resp_rdata     = resp_rdata_q;
    assign resp_err       = resp_err_q;
    assign mem_address    = mem_address_q;
    assign mem_w_en       = mem_w_en_q;
    assign mem_write_data = mem_write_data_q;

endmodule
